cmd_dispatcher: RTL and testbench

Sits directly downstream of the EBI command FIFO. Pops 80-bit commands written by the host, holds each one until the global clock reaches its start time, then presents it to the pin-controller bus with a valid/ready handshake. Commands are issued strictly in FIFO order, one at a time; this is the block that turns host-written command words into timed controller actions.

---
 rtl/cmd_dispatcher_pkg.sv | 40 ++++
 rtl/cmd_time_cmp.sv | 23 ++
 rtl/cmd_dispatcher.sv | 105 ++++++++++
 tb/tb_cmd_dispatcher.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_dispatcher_pkg.sv
// Shared definitions for the command dispatcher: command word layout, FSM encoding
// and the decoded command type.
package cmd_dispatcher_pkg;

    localparam int CMD_W          = 80;
    localparam int CMD_ADDR_MSB   = 79;
    localparam int CMD_ADDR_LSB   = 72;
    localparam int CMD_OP_MSB     = 71;
    localparam int CMD_OP_LSB     = 64;
    localparam int CMD_START_MSB  = 63;
    localparam int CMD_START_LSB  = 32;
    localparam int CMD_DATA_MSB   = 31;
    localparam int CMD_DATA_LSB   = 0;

    localparam logic [7:0] NOP_OPCODE_DEFAULT = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_FETCH = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_ISSUE = 4'b1000
    } state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  opcode;
        logic [31:0] start_time;
        logic [31:0] data;
    } cmd_t;

    function automatic cmd_t cmd_decode(input logic [CMD_W-1:0] word);
        cmd_t c;
        c.addr       = word[CMD_ADDR_MSB:CMD_ADDR_LSB];
        c.opcode     = word[CMD_OP_MSB:CMD_OP_LSB];
        c.start_time = word[CMD_START_MSB:CMD_START_LSB];
        c.data       = word[CMD_DATA_MSB:CMD_DATA_LSB];
        return c;
    endfunction

endpackage

// File: rtl/cmd_time_cmp.sv
// Combinational wrap-safe time compare: a command is due once the signed distance
// from its start time is non-negative, and late once it exceeds late_limit.
module cmd_time_cmp
    import cmd_dispatcher_pkg::*;
(
    input  logic [31:0] now,
    input  logic [31:0] start_time,
    input  logic [31:0] late_limit,
    output logic        due,
    output logic        late
);

    logic signed [31:0] delta;
    logic signed [31:0] limit_s;

    assign delta   = signed'(now - start_time);
    assign limit_s = signed'(late_limit);

    // start_time 0 means "run now", so it is always due and never counted late.
    assign due  = (start_time == 32'd0) || (delta >= 32'sd0);
    assign late = (start_time != 32'd0) && (delta > limit_s);

endmodule

// File: rtl/cmd_dispatcher.sv
// Pops timed commands from the command FIFO, holds each until its start time and
// issues it to the controller bus. Optional late-command dropping: CMD_LATE_DROP_EN.
module cmd_dispatcher
    import cmd_dispatcher_pkg::*;
#(
    parameter logic [31:0] LATE_LIMIT = 32'd1000,
    parameter logic [7:0]  NOP_OPCODE = NOP_OPCODE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] global_clock,
    input  logic        flush,
    input  logic [79:0] cmd_fifo_data_out,
    output logic        cmd_fifo_rd_en,
    input  logic        cmd_fifo_empty,
    output logic [7:0]  ctrl_addr,
    output logic [7:0]  ctrl_opcode,
    output logic [31:0] ctrl_data,
    output logic        ctrl_valid,
    input  logic        ctrl_ready,
    output logic        busy,
    output logic [15:0] late_count
);

    state_t state;
    cmd_t   hold;
    logic   cmd_due;
    logic   cmd_late;

    cmd_time_cmp u_time_cmp (
        .now        (global_clock),
        .start_time (hold.start_time),
        .late_limit (LATE_LIMIT),
        .due        (cmd_due),
        .late       (cmd_late)
    );

    // Pop is combinational in IDLE so the FIFO data lands exactly in FETCH.
    assign cmd_fifo_rd_en = rst && (state == ST_IDLE) && !cmd_fifo_empty && !flush;
    assign busy           = (state != ST_IDLE);

`ifdef CMD_LATE_DROP_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`else
    logic late_unused;
    assign late_unused = cmd_late;
    assign late_count  = 16'd0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            hold        <= '0;
            ctrl_valid  <= 1'b0;
            ctrl_addr   <= 8'd0;
            ctrl_opcode <= 8'd0;
            ctrl_data   <= 32'd0;
`ifdef CMD_LATE_DROP_EN
            late_count  <= 16'd0;
`endif
        end else if (flush) begin
            state      <= ST_IDLE;
            ctrl_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!cmd_fifo_empty) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    hold  <= cmd_decode(cmd_fifo_data_out);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (hold.opcode == NOP_OPCODE) begin
                        state <= ST_IDLE;
`ifdef CMD_LATE_DROP_EN
                    end else if (cmd_late) begin
                        state      <= ST_IDLE;
                        late_count <= sat_inc16(late_count);
`endif
                    end else if (cmd_due) begin
                        state       <= ST_ISSUE;
                        ctrl_valid  <= 1'b1;
                        ctrl_addr   <= hold.addr;
                        ctrl_opcode <= hold.opcode;
                        ctrl_data   <= hold.data;
                    end
                end
                ST_ISSUE: begin
                    if (ctrl_ready) begin
                        state      <= ST_IDLE;
                        ctrl_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    ctrl_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed self-checking bench for cmd_dispatcher with a simple standard-read FIFO model.
module tb_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] global_clock;
    logic        flush;
    logic [79:0] cmd_fifo_data_out = '0;
    logic        cmd_fifo_rd_en;
    logic        cmd_fifo_empty;
    logic [7:0]  ctrl_addr;
    logic [7:0]  ctrl_opcode;
    logic [31:0] ctrl_data;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic        busy;
    logic [15:0] late_count;

    int checks = 0;
    int errors = 0;

    logic [79:0] fifo_mem [0:63];
    logic [5:0]  wr_ptr = 6'd0;
    logic [5:0]  rd_ptr = 6'd0;

    always #5 clk = ~clk;

    assign cmd_fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (cmd_fifo_rd_en) begin
            cmd_fifo_data_out <= fifo_mem[rd_ptr];
            rd_ptr            <= rd_ptr + 6'd1;
        end
    end

    cmd_dispatcher dut (
        .clk               (clk),
        .rst               (rst),
        .global_clock      (global_clock),
        .flush             (flush),
        .cmd_fifo_data_out (cmd_fifo_data_out),
        .cmd_fifo_rd_en    (cmd_fifo_rd_en),
        .cmd_fifo_empty    (cmd_fifo_empty),
        .ctrl_addr         (ctrl_addr),
        .ctrl_opcode       (ctrl_opcode),
        .ctrl_data         (ctrl_data),
        .ctrl_valid        (ctrl_valid),
        .ctrl_ready        (ctrl_ready),
        .busy              (busy),
        .late_count        (late_count)
    );

    task automatic push(input logic [7:0] a, input logic [7:0] op,
                        input logic [31:0] st, input logic [31:0] d);
        fifo_mem[wr_ptr] = {a, op, st, d};
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ctrl_valid); end
        checks++; if (cmd_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b want 0", cmd_fifo_rd_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (late_count !== 16'd0) begin errors++; $display("FAIL reset_late_count: got %0d want 0", late_count); end
        checks++; if ({ctrl_addr, ctrl_opcode, ctrl_data} !== 48'd0) begin errors++; $display("FAIL reset_fields: got %h want 0", {ctrl_addr, ctrl_opcode, ctrl_data}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_immediate();
        ctrl_ready   = 1'b1;
        global_clock = 32'd0;
        push(8'h03, 8'h01, 32'd0, 32'hCAFEBABE);
        #1;
        checks++; if (cmd_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL imm_rd_en_c0: got %0b want 1", cmd_fifo_rd_en); end
        @(negedge clk); #1;
        checks++; if ({ctrl_valid, cmd_fifo_rd_en} !== 2'b00) begin errors++; $display("FAIL imm_c1: got valid/rd_en %b want 00", {ctrl_valid, cmd_fifo_rd_en}); end
        @(negedge clk); #1;
        checks++; if ({ctrl_valid, busy} !== 2'b01) begin errors++; $display("FAIL imm_c2: got valid/busy %b want 01", {ctrl_valid, busy}); end
        @(negedge clk); #1;
        checks++; if (ctrl_valid !== 1'b1) begin errors++; $display("FAIL imm_valid_c3: got %0b want 1", ctrl_valid); end
        checks++; if ({ctrl_addr, ctrl_opcode, ctrl_data} !== {8'h03, 8'h01, 32'hCAFEBABE}) begin errors++; $display("FAIL imm_fields: got %h want 0301cafebabe", {ctrl_addr, ctrl_opcode, ctrl_data}); end
        @(negedge clk); #1;
        checks++; if ({ctrl_valid, busy} !== 2'b00) begin errors++; $display("FAIL imm_c4: got valid/busy %b want 00", {ctrl_valid, busy}); end
        @(negedge clk);
    endtask

    task automatic test_timed();
        int rise = -1;
        logic [7:0] seen_addr = 8'd0;
        ctrl_ready = 1'b1;
        push(8'h11, 8'h02, 32'd150, 32'h12345678);
        for (int k = 0; k < 80; k++) begin
            global_clock = 32'd100 + 32'(k);
            #1;
            if (ctrl_valid && rise < 0) begin rise = k; seen_addr = ctrl_addr; end
            @(negedge clk);
        end
        checks++; if (rise != 51) begin errors++; $display("FAIL timed_rise: got cycle %0d want 51", rise); end
        checks++; if (seen_addr !== 8'h11) begin errors++; $display("FAIL timed_addr: got %h want 11", seen_addr); end
    endtask

    task automatic test_back_pressure();
        int rise = -1;
        logic [7:0] seen_addr = 8'd0;
        ctrl_ready   = 1'b0;
        global_clock = 32'd0;
        push(8'h22, 8'h07, 32'd0, 32'hDEAD0001);
        push(8'h33, 8'h08, 32'd0, 32'hDEAD0002);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            #1;
            checks++;
            if ({ctrl_valid, cmd_fifo_rd_en, ctrl_addr, ctrl_opcode, ctrl_data} !== {1'b1, 1'b0, 8'h22, 8'h07, 32'hDEAD0001}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid=%0b rd_en=%0b fields=%h want valid=1 rd_en=0 fields=2207dead0001",
                         k, ctrl_valid, cmd_fifo_rd_en, {ctrl_addr, ctrl_opcode, ctrl_data});
            end
            @(negedge clk);
        end
        ctrl_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if ({busy, ctrl_valid, cmd_fifo_rd_en} !== 3'b001) begin errors++; $display("FAIL bp_release: got busy/valid/rd_en %b want 001", {busy, ctrl_valid, cmd_fifo_rd_en}); end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk); #1;
            if (ctrl_valid && rise < 0) begin rise = k; seen_addr = ctrl_addr; end
        end
        checks++; if (rise != 3) begin errors++; $display("FAIL bp_second_rise: got cycle %0d want 3", rise); end
        checks++; if (seen_addr !== 8'h33) begin errors++; $display("FAIL bp_second_addr: got %h want 33", seen_addr); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int rise = -1;
        ctrl_ready = 1'b1;
        push(8'h44, 8'h03, 32'h00000010, 32'h0000BEEF);
        for (int k = 0; k < 60; k++) begin
            global_clock = 32'hFFFFFFF0 + 32'(k);
            #1;
            if (ctrl_valid && rise < 0) rise = k;
            @(negedge clk);
        end
        checks++; if (rise != 33) begin errors++; $display("FAIL wrap_rise: got cycle %0d want 33", rise); end
    endtask

    task automatic test_late();
        int rise = -1;
        ctrl_ready   = 1'b1;
        global_clock = 32'd5000;
        push(8'h45, 8'h04, 32'd1000, 32'h0000_0042);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (ctrl_valid && rise < 0) rise = k;
            @(negedge clk);
        end
        #1;
`ifdef CMD_LATE_DROP_EN
        checks++; if (rise != -1) begin errors++; $display("FAIL late_drop_valid: got rise %0d want none", rise); end
        checks++; if (late_count !== 16'd1) begin errors++; $display("FAIL late_drop_count: got %0d want 1", late_count); end
`else
        checks++; if (rise != 3) begin errors++; $display("FAIL late_issue_rise: got cycle %0d want 3", rise); end
        checks++; if (late_count !== 16'd0) begin errors++; $display("FAIL late_issue_count: got %0d want 0", late_count); end
`endif
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL late_busy: got %0b want 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_nop();
        int rise = -1;
        ctrl_ready   = 1'b1;
        global_clock = 32'd0;
        push(8'h05, 8'h00, 32'd0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            #1;
            if (ctrl_valid && rise < 0) rise = k;
            @(negedge clk);
        end
        #1;
        checks++; if (rise != -1) begin errors++; $display("FAIL nop_valid: got rise %0d want none", rise); end
        checks++; if ({busy, cmd_fifo_empty} !== 2'b01) begin errors++; $display("FAIL nop_drained: got busy/empty %b want 01", {busy, cmd_fifo_empty}); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        ctrl_ready   = 1'b0;
        global_clock = 32'd0;
        push(8'h46, 8'h09, 32'd1000, 32'h0);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_wait: got busy %0b want 1", busy); end
        @(negedge clk);
        push(8'h55, 8'h0A, 32'd0, 32'h0000ABCD);
        #1;
        checks++; if ({busy, ctrl_valid, cmd_fifo_rd_en} !== 3'b000) begin errors++; $display("FAIL flush_wait_idle: got busy/valid/rd_en %b want 000", {busy, ctrl_valid, cmd_fifo_rd_en}); end
        flush = 1'b0;
        #1;
        checks++; if (cmd_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL flush_resume_rd_en: got %0b want 1", cmd_fifo_rd_en); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({ctrl_valid, ctrl_addr} !== {1'b1, 8'h55}) begin errors++; $display("FAIL flush_issue_pre: got valid/addr %h want 155", {ctrl_valid, ctrl_addr}); end
        flush = 1'b1;
        @(negedge clk); #1;
        checks++; if ({busy, ctrl_valid} !== 2'b00) begin errors++; $display("FAIL flush_issue_idle: got busy/valid %b want 00", {busy, ctrl_valid}); end
        flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        ctrl_ready   = 1'b0;
        global_clock = 32'd0;
        push(8'h66, 8'h0B, 32'd0, 32'h11112222);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ctrl_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %0b want 1", ctrl_valid); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({ctrl_valid, busy, cmd_fifo_rd_en} !== 3'b000) begin errors++; $display("FAIL rstmid_ctrl: got valid/busy/rd_en %b want 000", {ctrl_valid, busy, cmd_fifo_rd_en}); end
        checks++; if ({ctrl_addr, ctrl_opcode, ctrl_data} !== 48'd0) begin errors++; $display("FAIL rstmid_fields: got %h want 0", {ctrl_addr, ctrl_opcode, ctrl_data}); end
        checks++; if (late_count !== 16'd0) begin errors++; $display("FAIL rstmid_late_count: got %0d want 0", late_count); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        ctrl_ready   = 1'b0;
        global_clock = 32'd0;
        test_reset();
        test_immediate();
        test_timed();
        test_back_pressure();
        test_wrap();
        test_late();
        test_nop();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
